// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte transmit FIFO feeding the UART transmitter; UART_TX_FIFO_OVF_EN builds the sticky overflow flag
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_busy,
  output logic          o_overflow,
  input  logic          i_ovf_clr,
  output logic          o_send,
  output logic [7:0]    o_data_in,
  input  logic          i_tx_active,
  input  logic          i_tx_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_full;
  logic            r_empty;
  logic            r_busy;
  logic            r_send;
  logic [7:0]      r_data_in;
  logic            w_push;
  logic            w_pop;

  // A full FIFO refuses writes even if a pop happens in the same cycle.
  assign w_push = i_wr_en && !r_full;
  // Pop only when the transmitter is free, so a frame left running across a reset is never overrun.
  assign w_pop  = (r_state == S_IDLE) && !r_empty && !i_tx_active;

  // Occupancy after this cycle's push/pop; feeds the registered full/empty flags.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Launch FSM next state; a done pulse in WAIT_START wins so short frames never strand the FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (w_pop) w_state_nxt = S_LAUNCH;
      S_LAUNCH:     w_state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (i_tx_done)        w_state_nxt = S_IDLE;
        else if (i_tx_active) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE:  if (i_tx_done) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Byte storage; contents need no reset because occupancy governs what is read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers, occupancy, FSM state and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_busy    <= 1'b0;
      r_send    <= 1'b0;
      r_data_in <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_send  <= (w_state_nxt == S_LAUNCH);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_data_in <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // Sticky overflow; a dropped write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_reset)                  r_overflow <= 1'b0;
    else if (i_wr_en && r_full)   r_overflow <= 1'b1;
    else if (i_ovf_clr)           r_overflow <= 1'b0;
  end

  assign o_overflow = r_overflow;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = i_ovf_clr;
  assign o_overflow       = 1'b0;
`endif

  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;
  assign o_busy    = r_busy;
  assign o_send    = r_send;
  assign o_data_in = r_data_in;

endmodule
